// File: rtl/res_station_pool_pkg.sv
// Shared definitions for the reservation-station pool: entry state encoding,
// the "no producer" tag value and the unknown-operand fill pattern.
package res_station_pool_pkg;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_t;

  localparam int TAG_NONE = 0;

  // Sign-extended 16'hFFF0; modules slice the low DATA_W bits.
  localparam logic [63:0] V_UNKNOWN_EXT = 64'hFFFF_FFFF_FFFF_FFF0;

endpackage

// File: rtl/res_station_pool_entry.sv
// rs_entry: one reservation slot; loads on issue, snoops the CDB for operands,
// reaches READY one cycle after its last operand arrives, frees on its own tag.
module rs_entry
  import res_station_pool_pkg::*;
#(
  parameter int              DATA_W = 16,
  parameter int              TAG_W  = 3,
  parameter int              OP_W   = 3,
  parameter int              IMM_W  = 7,
  parameter logic [TAG_W-1:0] MY_TAG = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [OP_W-1:0]   load_op,
  input  logic [IMM_W-1:0]  load_imm,
  input  logic [DATA_W-1:0] load_vj,
  input  logic [DATA_W-1:0] load_vk,
  input  logic [TAG_W-1:0]  load_qj,
  input  logic [TAG_W-1:0]  load_qk,
  input  logic              dispatch,
  input  logic              Cdb_valid,
  input  logic [TAG_W-1:0]  Cdb_tag,
  input  logic [DATA_W-1:0] Cdb_data,
  output logic              is_free,
  output logic              is_ready,
  output logic              is_busy,
  output logic [OP_W-1:0]   op,
  output logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  localparam logic [DATA_W-1:0] V_UNKNOWN = V_UNKNOWN_EXT[DATA_W-1:0];
  localparam logic [TAG_W-1:0]  Q_NONE    = TAG_W'(TAG_NONE);

  rs_state_t state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] vj_q, vk_q;
  logic [TAG_W-1:0]  qj_q, qk_q;
  logic              qj_hit, qk_hit, own_done;

  assign qj_hit   = Cdb_valid && (qj_q != Q_NONE) && (Cdb_tag == qj_q);
  assign qk_hit   = Cdb_valid && (qk_q != Q_NONE) && (Cdb_tag == qk_q);
  assign own_done = Cdb_valid && (Cdb_tag == MY_TAG);

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= RS_FREE;
    else       state_q <= state_d;
  end

  // WAIT looks at the registered Q fields, so wakeup lands a cycle after capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RS_FREE:  if (load) state_d = (load_qj == Q_NONE && load_qk == Q_NONE) ? RS_READY : RS_WAIT;
      RS_WAIT:  if (qj_q == Q_NONE && qk_q == Q_NONE) state_d = RS_READY;
      RS_READY: if (dispatch) state_d = RS_EXEC;
      RS_EXEC:  if (own_done) state_d = RS_FREE;
      default:  state_d = RS_FREE;
    endcase
  end

  always_comb begin
    is_free  = (state_q == RS_FREE);
    is_ready = (state_q == RS_READY);
    is_busy  = (state_q != RS_FREE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q  <= '0;
      imm_q <= '0;
      vj_q  <= V_UNKNOWN;
      vk_q  <= V_UNKNOWN;
      qj_q  <= Q_NONE;
      qk_q  <= Q_NONE;
    end else if (load && state_q == RS_FREE) begin
      op_q  <= load_op;
      imm_q <= load_imm;
      vj_q  <= (load_qj == Q_NONE) ? load_vj : V_UNKNOWN;
      vk_q  <= (load_qk == Q_NONE) ? load_vk : V_UNKNOWN;
      qj_q  <= load_qj;
      qk_q  <= load_qk;
    end else if (state_q == RS_WAIT) begin
      if (qj_hit) begin
        vj_q <= Cdb_data;
        qj_q <= Q_NONE;
      end
      if (qk_hit) begin
        vk_q <= Cdb_data;
        qk_q <= Q_NONE;
      end
    end
  end

  assign op  = op_q;
  assign imm = imm_q;
  assign vj  = vj_q;
  assign vk  = vk_q;

endmodule

// File: rtl/res_station_pool.sv
// Reservation-station pool: lowest-free allocation, lowest-READY dispatch, combinational handshakes.
// RS_CDB_BYPASS_EN forwards a same-cycle CDB result into the issuing entry; otherwise issue stalls on it.
module res_station_pool
  import res_station_pool_pkg::*;
#(
  parameter int ENTRIES  = 3,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int OP_W     = 3,
  parameter int IMM_W    = 7,
  parameter int BASE_TAG = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Issue_valid,
  output logic               Issue_ready,
  input  logic [OP_W-1:0]    Issue_op,
  input  logic [IMM_W-1:0]   Issue_imm,
  input  logic [DATA_W-1:0]  Issue_vj,
  input  logic [DATA_W-1:0]  Issue_vk,
  input  logic [TAG_W-1:0]   Issue_qj,
  input  logic [TAG_W-1:0]   Issue_qk,
  output logic [TAG_W-1:0]   Issue_tag,
  input  logic               Cdb_valid,
  input  logic [TAG_W-1:0]   Cdb_tag,
  input  logic [DATA_W-1:0]  Cdb_data,
  output logic               Fu_valid,
  input  logic               Fu_ready,
  output logic [OP_W-1:0]    Fu_op,
  output logic [DATA_W-1:0]  Fu_vj,
  output logic [DATA_W-1:0]  Fu_vk,
  output logic [IMM_W-1:0]   Fu_imm,
  output logic [TAG_W-1:0]   Fu_tag,
  output logic [ENTRIES-1:0] Busy_vec
);

  localparam int          IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [TAG_W-1:0] Q_NONE = TAG_W'(TAG_NONE);

  logic [ENTRIES-1:0] free_vec, ready_vec, load_vec, disp_vec;
  logic [OP_W-1:0]    op_a  [ENTRIES];
  logic [IMM_W-1:0]   imm_a [ENTRIES];
  logic [DATA_W-1:0]  vj_a  [ENTRIES];
  logic [DATA_W-1:0]  vk_a  [ENTRIES];

  logic               alloc_found, disp_found, stall, issue_fire;
  logic [IDX_W-1:0]   alloc_idx, disp_idx;
  logic [DATA_W-1:0]  ld_vj, ld_vk;
  logic [TAG_W-1:0]   ld_qj, ld_qk;

`ifdef RS_CDB_BYPASS_EN
  logic fwd_j, fwd_k;
  assign fwd_j = Cdb_valid && (Issue_qj != Q_NONE) && (Cdb_tag == Issue_qj);
  assign fwd_k = Cdb_valid && (Issue_qk != Q_NONE) && (Cdb_tag == Issue_qk);
  assign ld_vj = fwd_j ? Cdb_data : Issue_vj;
  assign ld_vk = fwd_k ? Cdb_data : Issue_vk;
  assign ld_qj = fwd_j ? Q_NONE : Issue_qj;
  assign ld_qk = fwd_k ? Q_NONE : Issue_qk;
  assign stall = 1'b0;
`else
  // Without forwarding, an operand broadcast this cycle would be missed by the new entry.
  assign ld_vj = Issue_vj;
  assign ld_vk = Issue_vk;
  assign ld_qj = Issue_qj;
  assign ld_qk = Issue_qk;
  assign stall = Cdb_valid && (((Issue_qj != Q_NONE) && (Cdb_tag == Issue_qj)) ||
                               ((Issue_qk != Q_NONE) && (Cdb_tag == Issue_qk)));
`endif

  // Downward scans so the lowest matching index is the last one written.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    disp_found  = 1'b0;
    disp_idx    = '0;
    Fu_op       = '0;
    Fu_imm      = '0;
    Fu_vj       = '0;
    Fu_vk       = '0;
    Fu_tag      = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
        Fu_op      = op_a[i];
        Fu_imm     = imm_a[i];
        Fu_vj      = vj_a[i];
        Fu_vk      = vk_a[i];
        Fu_tag     = TAG_W'(BASE_TAG + i);
      end
    end
  end

  assign Issue_ready = alloc_found && !Reset && !stall;
  assign Issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(alloc_idx);
  assign issue_fire  = Issue_valid && Issue_ready;
  assign Fu_valid    = disp_found && !Reset;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign load_vec[g] = issue_fire && (alloc_idx == IDX_W'(g));
    assign disp_vec[g] = Fu_valid && Fu_ready && (disp_idx == IDX_W'(g));

    rs_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .OP_W   (OP_W),
      .IMM_W  (IMM_W),
      .MY_TAG (TAG_W'(BASE_TAG + g))
    ) u_ent (
      .Clock    (Clock),
      .Reset    (Reset),
      .load     (load_vec[g]),
      .load_op  (Issue_op),
      .load_imm (Issue_imm),
      .load_vj  (ld_vj),
      .load_vk  (ld_vk),
      .load_qj  (ld_qj),
      .load_qk  (ld_qk),
      .dispatch (disp_vec[g]),
      .Cdb_valid(Cdb_valid),
      .Cdb_tag  (Cdb_tag),
      .Cdb_data (Cdb_data),
      .is_free  (free_vec[g]),
      .is_ready (ready_vec[g]),
      .is_busy  (Busy_vec[g]),
      .op       (op_a[g]),
      .imm      (imm_a[g]),
      .vj       (vj_a[g]),
      .vk       (vk_a[g])
    );
  end

endmodule

// File: tb/tb_res_station_pool.sv
// Scenario bench for res_station_pool; dispatch payloads are checked against a scoreboard queue.
module tb_res_station_pool;

  typedef struct packed {
    logic [2:0]  op;
    logic [6:0]  imm;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  tag;
  } disp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Issue_valid;
  logic        Issue_ready;
  logic [2:0]  Issue_op;
  logic [6:0]  Issue_imm;
  logic [15:0] Issue_vj, Issue_vk;
  logic [2:0]  Issue_qj, Issue_qk;
  logic [2:0]  Issue_tag;
  logic        Cdb_valid;
  logic [2:0]  Cdb_tag;
  logic [15:0] Cdb_data;
  logic        Fu_valid;
  logic        Fu_ready;
  logic [2:0]  Fu_op;
  logic [15:0] Fu_vj, Fu_vk;
  logic [6:0]  Fu_imm;
  logic [2:0]  Fu_tag;
  logic [2:0]  Busy_vec;

  int    checks   = 0;
  int    failures = 0;
  disp_t sb[$];
  disp_t exp_d, obs_d;

  always #5 Clock = ~Clock;

  res_station_pool dut (
    .Clock(Clock), .Reset(Reset),
    .Issue_valid(Issue_valid), .Issue_ready(Issue_ready),
    .Issue_op(Issue_op), .Issue_imm(Issue_imm),
    .Issue_vj(Issue_vj), .Issue_vk(Issue_vk),
    .Issue_qj(Issue_qj), .Issue_qk(Issue_qk), .Issue_tag(Issue_tag),
    .Cdb_valid(Cdb_valid), .Cdb_tag(Cdb_tag), .Cdb_data(Cdb_data),
    .Fu_valid(Fu_valid), .Fu_ready(Fu_ready),
    .Fu_op(Fu_op), .Fu_vj(Fu_vj), .Fu_vk(Fu_vk), .Fu_imm(Fu_imm), .Fu_tag(Fu_tag),
    .Busy_vec(Busy_vec)
  );

  assign obs_d = {Fu_op, Fu_imm, Fu_vj, Fu_vk, Fu_tag};

  task automatic drive_issue(input logic [2:0] op, input logic [6:0] imm,
                             input logic [15:0] vj, input logic [15:0] vk,
                             input logic [2:0] qj, input logic [2:0] qk);
    Issue_valid = 1'b1;
    Issue_op = op; Issue_imm = imm;
    Issue_vj = vj; Issue_vk = vk;
    Issue_qj = qj; Issue_qk = qk;
  endtask

  task automatic issue_off();
    Issue_valid = 1'b0;
    Issue_qj = 3'd0;
    Issue_qk = 3'd0;
  endtask

  task automatic drive_cdb(input logic vld, input logic [2:0] tag, input logic [15:0] data);
    Cdb_valid = vld; Cdb_tag = tag; Cdb_data = data;
  endtask

  task automatic test_reset();
    Reset = 1'b1; issue_off(); drive_cdb(1'b0, 3'd0, 16'd0); Fu_ready = 1'b0;
    Issue_op = '0; Issue_imm = '0; Issue_vj = '0; Issue_vk = '0;
    repeat (2) @(negedge Clock);
    #1;
    checks++; if (Issue_ready !== 1'b0) begin failures++; $display("FAIL reset_issue_ready got=%b exp=0", Issue_ready); end
    checks++; if (Fu_valid !== 1'b0) begin failures++; $display("FAIL reset_fu_valid got=%b exp=0", Fu_valid); end
    checks++; if (Busy_vec !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", Busy_vec); end
    @(negedge Clock); Reset = 1'b0; #1;
    checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'd1}) begin failures++; $display("FAIL reset_release got=%b/%0d exp=1/1", Issue_ready, Issue_tag); end
  endtask

  task automatic test_basic();
    @(negedge Clock); drive_issue(3'd2, 7'd3, 16'd5, 16'd7, 3'd0, 3'd0); #1;
    checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'd1}) begin failures++; $display("FAIL basic_issue got=%b/%0d exp=1/1", Issue_ready, Issue_tag); end
    sb.push_back('{op:3'd2, imm:7'd3, vj:16'd5, vk:16'd7, tag:3'd1});
    @(negedge Clock); issue_off(); Fu_ready = 1'b1; #1;
    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL basic_dispatch got=%b/%h exp=1/%h", Fu_valid, obs_d, exp_d); end
    @(negedge Clock); Fu_ready = 1'b0; drive_cdb(1'b1, 3'd1, 16'h00AA); #1;
    checks++; if ({Fu_valid, Busy_vec} !== {1'b0, 3'b001}) begin failures++; $display("FAIL basic_exec got=%b/%b exp=0/001", Fu_valid, Busy_vec); end
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if (Busy_vec !== 3'b000) begin failures++; $display("FAIL basic_free got=%b exp=000", Busy_vec); end
  endtask

  task automatic test_wakeup();
    @(negedge Clock); drive_issue(3'd5, 7'd1, 16'h1234, 16'h0011, 3'd3, 3'd0); #1;
    checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'd1}) begin failures++; $display("FAIL wake_issue got=%b/%0d exp=1/1", Issue_ready, Issue_tag); end
    sb.push_back('{op:3'd5, imm:7'd1, vj:16'h0042, vk:16'h0011, tag:3'd1});
    @(negedge Clock); issue_off(); drive_cdb(1'b1, 3'd3, 16'h0042); #1;
    checks++; if ({Fu_valid, Busy_vec} !== {1'b0, 3'b001}) begin failures++; $display("FAIL wake_wait got=%b/%b exp=0/001", Fu_valid, Busy_vec); end
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if (Fu_valid !== 1'b0) begin failures++; $display("FAIL wake_no_same_cycle got=%b exp=0", Fu_valid); end
    @(negedge Clock); Fu_ready = 1'b1; #1;
    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL wake_dispatch got=%b/%h exp=1/%h", Fu_valid, obs_d, exp_d); end
    @(negedge Clock); Fu_ready = 1'b0; drive_cdb(1'b1, 3'd1, 16'd0);
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if (Busy_vec !== 3'b000) begin failures++; $display("FAIL wake_free got=%b exp=000", Busy_vec); end
  endtask

  task automatic test_full();
    Fu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock); drive_issue(3'(k + 1), 7'(k), 16'(100 + k), 16'(200 + k), 3'd0, 3'd0); #1;
      checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'(k + 1)}) begin failures++; $display("FAIL full_issue%0d got=%b/%0d exp=1/%0d", k, Issue_ready, Issue_tag, k + 1); end
      sb.push_back('{op:3'(k + 1), imm:7'(k), vj:16'(100 + k), vk:16'(200 + k), tag:3'(k + 1)});
    end
    @(negedge Clock); issue_off(); #1;
    checks++; if ({Issue_ready, Busy_vec} !== {1'b0, 3'b111}) begin failures++; $display("FAIL full_stall got=%b/%b exp=0/111", Issue_ready, Busy_vec); end
    @(negedge Clock); Fu_ready = 1'b1; #1;
    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL full_dispatch0 got=%b/%h exp=1/%h", Fu_valid, obs_d, exp_d); end
    @(negedge Clock); Fu_ready = 1'b0; drive_cdb(1'b1, 3'd1, 16'h0BAD); #1;
    checks++; if (Issue_ready !== 1'b0) begin failures++; $display("FAIL full_free_same_cycle got=%b exp=0", Issue_ready); end
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'd1}) begin failures++; $display("FAIL full_realloc got=%b/%0d exp=1/1", Issue_ready, Issue_tag); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock); Fu_ready = 1'b1; #1;
      exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL b2b_dispatch%0d got=%b/%h exp=1/%h", k, Fu_valid, obs_d, exp_d); end
    end
    @(negedge Clock); Fu_ready = 1'b0; #1;
    checks++; if ({Fu_valid, Busy_vec} !== {1'b0, 3'b110}) begin failures++; $display("FAIL b2b_exec got=%b/%b exp=0/110", Fu_valid, Busy_vec); end
    @(negedge Clock); drive_cdb(1'b1, 3'd2, 16'd0);
    @(negedge Clock); drive_cdb(1'b1, 3'd3, 16'd0); #1;
    checks++; if (Busy_vec !== 3'b100) begin failures++; $display("FAIL b2b_free2 got=%b exp=100", Busy_vec); end
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if (Busy_vec !== 3'b000) begin failures++; $display("FAIL b2b_free3 got=%b exp=000", Busy_vec); end
  endtask

  task automatic test_bypass();
    @(negedge Clock); drive_issue(3'd1, 7'd2, 16'hAAAA, 16'd4, 3'd2, 3'd0); drive_cdb(1'b1, 3'd2, 16'd9); #1;
`ifdef RS_CDB_BYPASS_EN
    checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'd1}) begin failures++; $display("FAIL byp_issue got=%b/%0d exp=1/1", Issue_ready, Issue_tag); end
    sb.push_back('{op:3'd1, imm:7'd2, vj:16'd9, vk:16'd4, tag:3'd1});
    @(negedge Clock); issue_off(); drive_cdb(1'b0, 3'd0, 16'd0); Fu_ready = 1'b1; #1;
    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL byp_dispatch got=%b/%h exp=1/%h", Fu_valid, obs_d, exp_d); end
`else
    checks++; if (Issue_ready !== 1'b0) begin failures++; $display("FAIL byp_stall got=%b exp=0", Issue_ready); end
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if ({Issue_ready, Issue_tag} !== {1'b1, 3'd1}) begin failures++; $display("FAIL byp_retry got=%b/%0d exp=1/1", Issue_ready, Issue_tag); end
    sb.push_back('{op:3'd1, imm:7'd2, vj:16'd9, vk:16'd4, tag:3'd1});
    @(negedge Clock); issue_off(); drive_cdb(1'b1, 3'd2, 16'd9); #1;
    checks++; if (Fu_valid !== 1'b0) begin failures++; $display("FAIL byp_wait got=%b exp=0", Fu_valid); end
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0);
    @(negedge Clock); Fu_ready = 1'b1; #1;
    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL byp_dispatch got=%b/%h exp=1/%h", Fu_valid, obs_d, exp_d); end
`endif
    @(negedge Clock); Fu_ready = 1'b0; drive_cdb(1'b1, 3'd1, 16'd0);
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if (Busy_vec !== 3'b000) begin failures++; $display("FAIL byp_free got=%b exp=000", Busy_vec); end
  endtask

  task automatic test_cdb_ignore();
    @(negedge Clock); drive_issue(3'd3, 7'd5, 16'h1111, 16'h0077, 3'd5, 3'd0); #1;
    sb.push_back('{op:3'd3, imm:7'd5, vj:16'h0055, vk:16'h0077, tag:3'd1});
    @(negedge Clock); issue_off(); drive_cdb(1'b1, 3'd0, 16'hDEAD);
    @(negedge Clock); drive_cdb(1'b1, 3'd6, 16'hBEEF);
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if ({Fu_valid, Busy_vec} !== {1'b0, 3'b001}) begin failures++; $display("FAIL ign_still_wait got=%b/%b exp=0/001", Fu_valid, Busy_vec); end
    @(negedge Clock); drive_cdb(1'b1, 3'd5, 16'h0055);
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0);
    @(negedge Clock); Fu_ready = 1'b1; #1;
    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++; if ({Fu_valid, obs_d} !== {1'b1, exp_d}) begin failures++; $display("FAIL ign_dispatch got=%b/%h exp=1/%h", Fu_valid, obs_d, exp_d); end
    @(negedge Clock); Fu_ready = 1'b0; drive_cdb(1'b1, 3'd1, 16'd0);
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0);
  endtask

  task automatic test_reset_mid();
    @(negedge Clock); drive_issue(3'd4, 7'd0, 16'd1, 16'd2, 3'd5, 3'd0);
    @(negedge Clock); drive_issue(3'd6, 7'd0, 16'd3, 16'd4, 3'd0, 3'd5);
    @(negedge Clock); issue_off(); #1;
    checks++; if (Busy_vec !== 3'b011) begin failures++; $display("FAIL rst_mid_busy got=%b exp=011", Busy_vec); end
    @(negedge Clock); Reset = 1'b1; #1;
    checks++; if ({Issue_ready, Fu_valid} !== 2'b00) begin failures++; $display("FAIL rst_mid_hs got=%b/%b exp=0/0", Issue_ready, Fu_valid); end
    @(negedge Clock); Reset = 1'b0; #1;
    checks++; if ({Busy_vec, Fu_valid, Issue_tag} !== {3'b000, 1'b0, 3'd1}) begin failures++; $display("FAIL rst_mid_clear got=%b/%b/%0d exp=000/0/1", Busy_vec, Fu_valid, Issue_tag); end
    @(negedge Clock); drive_cdb(1'b1, 3'd5, 16'h0123);
    @(negedge Clock); drive_cdb(1'b1, 3'd1, 16'h0456);
    @(negedge Clock); drive_cdb(1'b0, 3'd0, 16'd0); #1;
    checks++; if ({Busy_vec, Fu_valid} !== {3'b000, 1'b0}) begin failures++; $display("FAIL rst_mid_late_cdb got=%b/%b exp=000/0", Busy_vec, Fu_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_back_to_back();
    test_bypass();
    test_cdb_ignore();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
